// File: rtl/logic_unit_seq_ctrl.sv
// Self-test sequencer: sweeps vectors 0..PATTERN_LAST into the registered logic unit and scores its outputs.
// Define SEQ_FIRST_ERR_EN to add the first-mismatch capture ports (o_first_err_vld / o_first_err_vec).
module logic_unit_seq_ctrl #(
  parameter int PATTERN_LAST = 31,
  parameter int ERR_CNT_W    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic [4:0]           o_dut_in,
  input  logic [2:0]           i_dut_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`ifdef SEQ_FIRST_ERR_EN
  ,
  output logic                 o_first_err_vld,
  output logic [4:0]           o_first_err_vec
`endif
);

  // Vector index is 5 bits wide, so anything past 31 would wrap; clamp instead.
  localparam logic [4:0] LAST_VEC = (PATTERN_LAST >= 31) ? 5'd31 : 5'(PATTERN_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [4:0]           r_vec;
  logic [4:0]           r_dut_in;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_CNT_W-1:0] r_err_cnt;
`ifdef SEQ_FIRST_ERR_EN
  logic                 r_first_vld;
  logic [4:0]           r_first_vec;
`endif

  logic [2:0]           w_golden;
  logic                 w_mismatch;
  logic [ERR_CNT_W-1:0] w_err_next;

  always_comb begin
    w_golden[0] = ~(~(r_vec[0] | r_vec[1]) & r_vec[2]);
    w_golden[1] = ~(r_vec[1] & r_vec[2]);
    w_golden[2] = ~r_vec[3] | r_vec[2] | r_vec[4];
  end

  assign w_mismatch = (i_dut_out != w_golden);
  assign w_err_next = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_dut_in  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
`ifdef SEQ_FIRST_ERR_EN
      r_first_vld <= 1'b0;
      r_first_vec <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (i_start) begin
            r_state   <= S_APPLY;
            r_vec     <= '0;
            r_dut_in  <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
`ifdef SEQ_FIRST_ERR_EN
            r_first_vld <= 1'b0;
            r_first_vec <= '0;
`endif
          end
        end

        S_APPLY: begin
          if (i_abort) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_dut_in <= '0;
          end else begin
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          // Abort skips scoring this vector; the count so far stays visible.
          if (i_abort) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_dut_in <= '0;
          end else begin
            r_err_cnt <= w_err_next;
`ifdef SEQ_FIRST_ERR_EN
            if (w_mismatch && !r_first_vld) begin
              r_first_vld <= 1'b1;
              r_first_vec <= r_vec;
            end
`endif
            if (r_vec == LAST_VEC) begin
              r_state  <= S_FIN;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (w_err_next == '0);
              r_dut_in <= '0;
            end else begin
              r_state  <= S_APPLY;
              r_vec    <= r_vec + 5'd1;
              r_dut_in <= r_vec + 5'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dut_in  = r_dut_in;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err_cnt;
`ifdef SEQ_FIRST_ERR_EN
  assign o_first_err_vld = r_first_vld;
  assign o_first_err_vec = r_first_vec;
`endif

endmodule

// File: tb/tb_logic_unit_seq_ctrl.sv
// Bench for logic_unit_seq_ctrl: three sequencers (full sweep, 4-vector sweep, 3-bit counter)
// each driving a behavioural logic unit with selectable faults, scored against a run-phase model.
module tb_logic_unit_seq_ctrl;

  localparam int NI = 3;
  localparam int LAST [NI] = '{31, 3, 31};
  localparam int SATV [NI] = '{63, 63, 7};
  localparam int SEQ_SHORT [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start  [NI];
  logic       abort  [NI];
  logic       busy   [NI];
  logic       done   [NI];
  logic       pass   [NI];
  logic [4:0] dut_in [NI];
  logic [2:0] lu_out [NI];
  logic       first_vld [NI];
  logic [4:0] first_vec [NI];
  logic [5:0] err0, err1;
  logic [2:0] err2;
  int         fault [NI];

  int n_checks = 0;
  int n_pass   = 0;

  logic_unit_seq_ctrl #(.PATTERN_LAST(31), .ERR_CNT_W(6)) u_dut_full (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_abort(abort[0]),
    .o_dut_in(dut_in[0]), .i_dut_out(lu_out[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_pass(pass[0]), .o_err_cnt(err0)
`ifdef SEQ_FIRST_ERR_EN
    , .o_first_err_vld(first_vld[0]), .o_first_err_vec(first_vec[0])
`endif
  );

  logic_unit_seq_ctrl #(.PATTERN_LAST(3), .ERR_CNT_W(6)) u_dut_short (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_abort(abort[1]),
    .o_dut_in(dut_in[1]), .i_dut_out(lu_out[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_pass(pass[1]), .o_err_cnt(err1)
`ifdef SEQ_FIRST_ERR_EN
    , .o_first_err_vld(first_vld[1]), .o_first_err_vec(first_vec[1])
`endif
  );

  logic_unit_seq_ctrl #(.PATTERN_LAST(31), .ERR_CNT_W(3)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_abort(abort[2]),
    .o_dut_in(dut_in[2]), .i_dut_out(lu_out[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_pass(pass[2]), .o_err_cnt(err2)
`ifdef SEQ_FIRST_ERR_EN
    , .o_first_err_vld(first_vld[2]), .o_first_err_vec(first_vec[2])
`endif
  );

  function automatic logic [2:0] golden(input logic [4:0] v);
    logic [2:0] g;
    g[0] = ~(~(v[0] | v[1]) & v[2]);
    g[1] = ~(v[1] & v[2]);
    g[2] = ~v[3] | v[2] | v[4];
    return g;
  endfunction

  // fault 0: healthy, 1: OUT2 stuck at 0, 2: all outputs forced low
  function automatic logic [2:0] unit_out(input int f, input logic [4:0] v);
    case (f)
      1:       return golden(v) & 3'b101;
      2:       return 3'b000;
      default: return golden(v);
    endcase
  endfunction

  function automatic int act_err(input int i);
    case (i)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Registered logic unit with one output stage.
  always @(posedge clk)
    for (int i = 0; i < NI; i++) lu_out[i] <= unit_out(fault[i], dut_in[i]);

  // Run model: k counts edges since the start edge; odd k scores vector k/2.
  bit m_busy [NI];
  bit m_done [NI];
  bit m_fvld [NI];
  int m_k    [NI];
  int m_err  [NI];
  int m_fvec [NI];
  int mv;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_done[i] = 0; m_fvld[i] = 0;
        m_k[i] = 0; m_err[i] = 0; m_fvec[i] = 0;
      end else if (m_busy[i]) begin
        if (abort[i]) begin
          m_busy[i] = 0;
        end else begin
          if (m_k[i] % 2 == 1) begin
            mv = m_k[i] / 2;
            if (unit_out(fault[i], mv[4:0]) != golden(mv[4:0])) begin
              if (!m_fvld[i]) begin
                m_fvld[i] = 1;
                m_fvec[i] = mv;
              end
              if (m_err[i] < SATV[i]) m_err[i] = m_err[i] + 1;
            end
            if (mv == LAST[i]) begin
              m_busy[i] = 0;
              m_done[i] = 1;
            end
          end
          m_k[i] = m_k[i] + 1;
        end
      end else if (abort[i]) begin
        m_done[i] = 0;
      end else if (start[i]) begin
        m_busy[i] = 1; m_done[i] = 0; m_fvld[i] = 0;
        m_k[i] = 0; m_err[i] = 0; m_fvec[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d_busy", i), int'(busy[i]), int'(m_busy[i]));
      check($sformatf("u%0d_done", i), int'(done[i]), int'(m_done[i]));
      check($sformatf("u%0d_pass", i), int'(pass[i]), int'(m_done[i] && m_err[i] == 0));
      check($sformatf("u%0d_err_cnt", i), act_err(i), m_err[i]);
      check($sformatf("u%0d_dut_in", i), int'(dut_in[i]), m_busy[i] ? m_k[i] / 2 : 0);
`ifdef SEQ_FIRST_ERR_EN
      check($sformatf("u%0d_first_vld", i), int'(first_vld[i]), int'(m_fvld[i]));
      check($sformatf("u%0d_first_vec", i), int'(first_vec[i]), m_fvec[i]);
`endif
    end
  end

  logic [4:0] seq_q [$];

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  // Returns edges from the start edge to DONE, recording DUT_IN once per cycle.
  task automatic wait_done(input int i, output int cyc);
    cyc = 0;
    seq_q.delete();
    seq_q.push_back(dut_in[i]);
    while (!done[i] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (!done[i]) seq_q.push_back(dut_in[i]);
    end
    if (!done[i]) check("done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cyc;

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
    end
    fault[0] = 0; fault[1] = 0; fault[2] = 2;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_pass", int'(pass[0]), 0);
    check("rst_err", act_err(0), 0);
    check("rst_dut_in", int'(dut_in[0]), 0);

    // Healthy unit, full sweep
    pulse_start(0);
    check("good_busy_at_e", int'(busy[0]), 1);
    wait_done(0, cyc);
    check("good_latency", cyc, 64);
    check("good_pass", int'(pass[0]), 1);
    check("good_err", act_err(0), 0);
    check("good_busy_fin", int'(busy[0]), 0);
`ifdef SEQ_FIRST_ERR_EN
    check("good_first_vld", int'(first_vld[0]), 0);
`endif

    // OUT2 stuck low: mismatch on every vector with v1&v2 == 0
    fault[0] = 1;
    pulse_start(0);
    wait_done(0, cyc);
    check("stuck_latency", cyc, 64);
    check("stuck_err", act_err(0), 24);
    check("stuck_pass", int'(pass[0]), 0);
`ifdef SEQ_FIRST_ERR_EN
    check("stuck_first_vld", int'(first_vld[0]), 1);
    check("stuck_first_vec", int'(first_vec[0]), 0);
`endif

    // Short sweep of four vectors
    pulse_start(1);
    wait_done(1, cyc);
    check("short_latency", cyc, 8);
    check("short_seq_len", seq_q.size(), 8);
    for (int j = 0; j < 8 && j < seq_q.size(); j++)
      check($sformatf("short_seq%0d", j), int'(seq_q[j]), SEQ_SHORT[j]);
    check("short_pass", int'(pass[1]), 1);

    // Abort after vectors 0..9 have been scored
    pulse_start(0);
    repeat (20) @(posedge clk);
    #1 abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    check("abort_busy", int'(busy[0]), 0);
    check("abort_done", int'(done[0]), 0);
    check("abort_err_held", act_err(0), 8);
    check("abort_dut_in", int'(dut_in[0]), 0);
    repeat (3) @(posedge clk);
    #1 check("abort_err_still", act_err(0), 8);
    pulse_start(0);
    check("relaunch_err_clr", act_err(0), 0);
    wait_done(0, cyc);
    check("relaunch_latency", cyc, 64);
    check("relaunch_err", act_err(0), 24);

    // Narrow counter, all outputs forced low: every vector mismatches
    pulse_start(2);
    wait_done(2, cyc);
    check("sat_latency", cyc, 64);
    check("sat_err", act_err(2), 7);
    check("sat_pass", int'(pass[2]), 0);

    // Asynchronous reset in the middle of a CHECK cycle
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1 check("arst_pre_err", act_err(0), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_clk_high", int'(clk), 1);
    check("arst_busy", int'(busy[0]), 0);
    check("arst_err", act_err(0), 0);
    check("arst_dut_in", int'(dut_in[0]), 0);
    check("arst_sat_err", act_err(2), 0);
`ifdef SEQ_FIRST_ERR_EN
    check("arst_first_vld", int'(first_vld[0]), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // START and ABORT together from FIN: abort wins
    pulse_start(1);
    wait_done(1, cyc);
    check("fin_done", int'(done[1]), 1);
    @(posedge clk); #1 begin start[1] = 1'b1; abort[1] = 1'b1; end
    @(posedge clk); #1 begin start[1] = 1'b0; abort[1] = 1'b0; end
    check("sa_done", int'(done[1]), 0);
    check("sa_busy", int'(busy[1]), 0);
    check("sa_pass", int'(pass[1]), 0);
    repeat (2) @(posedge clk);
    #1 check("sa_idle_busy", int'(busy[1]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
